// File: rtl/keypad_uart_pkg.sv
// Shared types and helpers for the keypad-to-UART transmit path.
package keypad_uart_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT} tx_state_t;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_W = 8'h57;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F', 16-19 -> 'W'-'Z'
    function automatic logic [7:0] code_to_ascii(input logic [4:0] code);
        logic [7:0] c;
        c = {3'b000, code};
        if (code < 5'd10)
            return ASCII_0 + c;
        else if (code < 5'd16)
            return ASCII_A + (c - 8'd10);
        else
            return ASCII_W + (c - 8'd16);
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Small show-ahead byte FIFO; dout always presents the head entry.
module key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/keypad_uart_tx.sv
// Push-button press -> key code -> ASCII byte -> FIFO -> UART strobe interface.
//
//   state | meaning
//   IDLE  | waiting for a queued byte and txready; loads txdata and pops on start
//   PULSE | txclk high for exactly one cycle
//   WAIT  | txdata held; returns to IDLE once txready is seen
module keypad_uart_tx
    import keypad_uart_pkg::*;
#(
    parameter int NKEYS = 20,
    parameter int DEPTH = 4
) (
    input  logic                     hz100,
    input  logic                     reset,
    input  logic [NKEYS-1:0]         pb,
    input  logic                     txready,
    output logic [7:0]               txdata,
    output logic                     txclk,
    output logic [4:0]               keycode,
    output logic                     keyvalid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    logic [NKEYS-1:0] s1;
    logic [NKEYS-1:0] s2;
    logic             prev;
    logic [1:0]       settle;
    logic             armed;
    logic             press;
    logic             push_ok;
    logic             pop;
    logic [4:0]       code;
    logic [7:0]       fifo_dout;
    logic             full;
    logic             empty;
    tx_state_t        state;

    always_comb begin
        code = '0;
        for (int i = 0; i < NKEYS; i++)
            if (s2[i])
                code = 5'(i);
    end

    // Buttons already held through reset must be released once before they count.
    assign press   = armed & (|s2) & ~prev;
    assign pop     = (state == IDLE) & ~empty & txready;
    assign push_ok = press & (~full | pop);

    always_ff @(posedge hz100) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= 1'b0;
            settle   <= 2'd2;
            armed    <= 1'b0;
            keycode  <= '0;
            keyvalid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            s1       <= pb;
            s2       <= s1;
            prev     <= |s2;
            keyvalid <= push_ok;
            if (settle != 2'd0)
                settle <= settle - 2'd1;
            else if (~|s2)
                armed <= 1'b1;
            if (push_ok)
                keycode <= code;
            if (press && !push_ok)
                overflow <= 1'b1;
        end
    end

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (hz100),
        .reset (reset),
        .push  (push_ok),
        .din   (code_to_ascii(code)),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge hz100) begin
        if (reset) begin
            state  <= IDLE;
            txdata <= '0;
            txclk  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txclk <= 1'b0;
                    if (pop) begin
                        txdata <= fifo_dout;
                        txclk  <= 1'b1;
                        state  <= PULSE;
                    end
                end
                PULSE: begin
                    txclk <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    txclk <= 1'b0;
                    if (txready)
                        state <= IDLE;
                end
                default: begin
                    txclk <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
